// File: rtl/bus_arb_defs.sv
// Shared definitions for the bus arbiter/buffer slice.
//   busState_e : FSM encoding (IDLE, DRIVE, TURNAROUND).
//   clog2      : ceiling log2, used to size owner and hold-counter fields.
package bus_arb_defs;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    DRIVE      = 2'd1,
    TURNAROUND = 2'd2
  } busState_e;

  // Ceiling log2; clog2(1) == 0, so callers clamp to a minimum width of 1.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result = result + 1;
    return result;
  endfunction

endpackage

// File: rtl/rr_select.sv
// Round-robin selector (purely combinational).
//   req    : request vector, one bit per source
//   rrPtr  : index where the search starts
//   found  : any request present
//   winner : first set req bit at or above rrPtr, wrapping NUM_SRC-1 -> 0
module rr_select
  import bus_arb_defs::*;
#(
  parameter int NUM_SRC = 4,
  parameter int PTR_W   = clog2(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic [PTR_W-1:0]   rrPtr,
  output logic               found,
  output logic [PTR_W-1:0]   winner
);

  assign found = |req;

  // Walk the offsets from farthest to nearest so the nearest set bit,
  // counted from rrPtr, is the last to write winner.
  always_comb begin
    int idx;
    logic [PTR_W-1:0] sel;
    winner = '0;
    idx    = 0;
    sel    = '0;
    for (int k = NUM_SRC - 1; k >= 0; k--) begin
      idx = int'(rrPtr) + k;
      if (idx >= NUM_SRC) idx = idx - NUM_SRC;
      sel = PTR_W'(idx);
      if (req[sel]) winner = sel;
    end
  end

endmodule

// File: rtl/bus_arbiter_buffer.sv
// Round-robin arbiter and registered tri-state driver for one shared bus.
// NUM_SRC producers compete for the bus. The winner's data is registered, and
// the bus is driven from that register. A one-cycle high-Z turnaround always
// separates two owners. MAX_HOLD (0 = unlimited) caps how many consecutive
// cycles one grant may drive.
//
// Request/grant handshake: req[i] is a level that the source holds for as
// long as it wants the bus. grant is registered and one-hot, and ownership
// lasts while grant[i]=1. Dropping req[i] releases the bus at the next edge.
// There is no separate ready: grant is the acknowledgement.
//
// Ports:
//   clk, reset  : clock, asynchronous active-high reset
//   req         : per-source request levels
//   data_in     : source i data in bits [i*WIDTH +: WIDTH]
//   grant       : one-hot registered grant, zero when the bus is unowned
//   owner_id    : index of the current owner, meaningful while bus_valid=1
//   bus_out     : shared bus, driven only in DRIVE, otherwise 'z
//   bus_valid   : high in DRIVE
//   dbgState    : FSM state, for observation
module bus_arbiter_buffer
  import bus_arb_defs::*;
#(
  parameter int WIDTH    = 16,
  parameter int NUM_SRC  = 4,
  parameter int MAX_HOLD = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_SRC-1:0]         req,
  input  logic [NUM_SRC*WIDTH-1:0]   data_in,
  output logic [NUM_SRC-1:0]         grant,
  output logic [clog2(NUM_SRC)-1:0]  owner_id,
  output logic [WIDTH-1:0]           bus_out,
  output logic                       bus_valid,
  output logic [1:0]                 dbgState
);

  localparam int OWN_W  = clog2(NUM_SRC);
  localparam int HOLD_W = (clog2(MAX_HOLD + 1) < 1) ? 1 : clog2(MAX_HOLD + 1);
  localparam logic [HOLD_W-1:0] HOLD_LIMIT = HOLD_W'(MAX_HOLD);
  // With an unlimited hold, the counter parks at all-ones instead of wrapping.
  localparam logic [HOLD_W-1:0] HOLD_SAT =
    (MAX_HOLD == 0) ? {HOLD_W{1'b1}} : HOLD_W'(MAX_HOLD);

  busState_e          state, nextState;
  logic [NUM_SRC-1:0] nextGrant;
  logic [OWN_W-1:0]   nextOwner;
  logic [WIDTH-1:0]   dataReg, nextData;
  logic [HOLD_W-1:0]  holdCnt, nextHold;
  logic [OWN_W-1:0]   rrPtr, nextPtr;
  logic               found;
  logic [OWN_W-1:0]   winner;
  logic [WIDTH-1:0]   ownerData, winnerData;
  logic               atLimit;

  rr_select #(
    .NUM_SRC (NUM_SRC),
    .PTR_W   (OWN_W)
  ) u_rr_select (
    .req    (req),
    .rrPtr  (rrPtr),
    .found  (found),
    .winner (winner)
  );

  assign ownerData  = data_in[int'(owner_id) * WIDTH +: WIDTH];
  assign winnerData = data_in[int'(winner) * WIDTH +: WIDTH];
  assign atLimit    = (MAX_HOLD != 0) && (holdCnt == HOLD_LIMIT);

  always_comb begin
    nextState = state;
    nextGrant = grant;
    nextOwner = owner_id;
    nextData  = dataReg;
    nextHold  = holdCnt;
    nextPtr   = rrPtr;
    case (state)
      DRIVE: begin
        if (!req[owner_id] || atLimit) begin
          // The pointer moves past the owner even on a forced release, so a
          // source that keeps requesting has to wait for the others.
          nextState = TURNAROUND;
          nextGrant = '0;
          nextPtr   = (owner_id == OWN_W'(NUM_SRC - 1)) ? '0 : owner_id + 1'b1;
        end else begin
          nextData = ownerData;
          if (holdCnt != HOLD_SAT) nextHold = holdCnt + 1'b1;
        end
      end
      default: begin
        // IDLE and TURNAROUND arbitrate the same way. The unused encoding
        // recovers through this path as well.
        if (found) begin
          nextState = DRIVE;
          nextGrant = {{(NUM_SRC - 1){1'b0}}, 1'b1} << winner;
          nextOwner = winner;
          nextData  = winnerData;
          nextHold  = HOLD_W'(1);
        end else begin
          nextState = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      grant    <= '0;
      owner_id <= '0;
      dataReg  <= '0;
      holdCnt  <= '0;
      rrPtr    <= '0;
    end else begin
      state    <= nextState;
      grant    <= nextGrant;
      owner_id <= nextOwner;
      dataReg  <= nextData;
      holdCnt  <= nextHold;
      rrPtr    <= nextPtr;
    end
  end

  // Decoded from the state register only. Reset therefore floats the bus at once.
  assign bus_valid = (state == DRIVE);
  assign bus_out   = bus_valid ? dataReg : {WIDTH{1'bz}};
  assign dbgState  = state;

endmodule

// File: tb/tb_bus_arbiter_buffer.sv
// Bench for bus_arbiter_buffer. Two instances share stimulus: one with
// MAX_HOLD=3 and one unlimited. Each instance is compared every cycle
// against a behavioural model of the arbitration rules.
module tb_bus_arbiter_buffer;

  localparam int W = 16;
  localparam int N = 4;
  localparam int ST_IDLE  = 0;
  localparam int ST_DRIVE = 1;
  localparam int ST_TURN  = 2;

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic [N-1:0]   req = '0;
  logic [N*W-1:0] dataIn = '0;

  logic [N-1:0] grantA, grantB;
  logic [1:0]   ownerA, ownerB;
  wire  [W-1:0] busA, busB;
  logic         validA, validB;
  logic [1:0]   dbgA, dbgB;

  bus_arbiter_buffer #(.WIDTH(W), .NUM_SRC(N), .MAX_HOLD(3)) dutA (
    .clk(clk), .reset(reset), .req(req), .data_in(dataIn), .grant(grantA),
    .owner_id(ownerA), .bus_out(busA), .bus_valid(validA), .dbgState(dbgA)
  );

  bus_arbiter_buffer #(.WIDTH(W), .NUM_SRC(N), .MAX_HOLD(0)) dutB (
    .clk(clk), .reset(reset), .req(req), .data_in(dataIn), .grant(grantB),
    .owner_id(ownerB), .bus_out(busB), .bus_valid(validB), .dbgState(dbgB)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  typedef struct {
    int         st;
    int         owner;
    int         ptr;
    int         hold;
    logic [W-1:0] data;
  } mdl_t;

  mdl_t mdl[2];
  int   maxHold[2];
  int   prevValid[2];
  int   prevOwner[2];
  int   compared = 0;
  int   mismatched = 0;

  function automatic mdl_t rstMdl();
    mdl_t r;
    r.st = ST_IDLE; r.owner = 0; r.ptr = 0; r.hold = 0; r.data = '0;
    return r;
  endfunction

  function automatic mdl_t modelStep(mdl_t s, int mh, logic [N-1:0] r,
                                     logic [N*W-1:0] d);
    mdl_t n;
    n = s;
    if (s.st == ST_DRIVE) begin
      if (!r[s.owner] || (mh != 0 && s.hold >= mh)) begin
        n.st  = ST_TURN;
        n.ptr = (s.owner + 1) % N;
      end else begin
        n.data = d[s.owner*W +: W];
        n.hold = s.hold + 1;
      end
    end else begin
      n.st = ST_IDLE;
      for (int k = 0; k < N; k++) begin
        int i;
        i = (s.ptr + k) % N;
        if (r[i]) begin
          n.st = ST_DRIVE; n.owner = i; n.data = d[i*W +: W]; n.hold = 1;
          break;
        end
      end
    end
    return n;
  endfunction

  // ---------------- scoreboard ----------------
  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic checkOne(input int u, input logic [N-1:0] g, input logic [1:0] o,
                          input logic [W-1:0] b, input logic v, input logic [1:0] ds);
    logic         expV;
    logic [N-1:0] expG;
    logic [W-1:0] zv;
    string        sfx;
    sfx  = (u == 0) ? "A" : "B";
    zv   = {W{1'bz}};
    expV = (mdl[u].st == ST_DRIVE);
    expG = expV ? (N'(1) << mdl[u].owner) : '0;
    chk({"valid", sfx}, 64'(v), 64'(expV));
    chk({"grant", sfx}, 64'(g), 64'(expG));
    chk({"state", sfx}, 64'(ds), 64'(mdl[u].st));
    if (expV) begin
      chk({"owner", sfx}, 64'(o), 64'(mdl[u].owner));
      chk({"bus", sfx}, 64'(b), 64'(mdl[u].data));
    end else begin
      chk({"bus_z", sfx}, 64'(b), 64'(zv));
    end
    if (v) begin
      chk({"onehot", sfx}, 64'($onehot(g)), 64'd1);
      if (prevValid[u] != 0) chk({"no_switch", sfx}, 64'(o), 64'(prevOwner[u]));
    end
    prevValid[u] = int'(v);
    prevOwner[u] = int'(o);
  endtask

  task automatic checkAll();
    checkOne(0, grantA, ownerA, busA, validA, dbgA);
    checkOne(1, grantB, ownerB, busB, validB, dbgB);
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    for (int u = 0; u < 2; u++)
      mdl[u] = reset ? rstMdl() : modelStep(mdl[u], maxHold[u], req, dataIn);
    #1;
    checkAll();
  endtask

  // Asynchronous reset between edges, checked immediately, held through one edge.
  task automatic doReset();
    reset = 1'b1;
    for (int u = 0; u < 2; u++) begin
      mdl[u] = rstMdl();
      prevValid[u] = 0;
    end
    #1;
    checkAll();
    tick();
    reset = 1'b0;
  endtask

  task automatic setData(input int src, input logic [W-1:0] val);
    dataIn[src*W +: W] = val;
  endtask

  // ---------------- directed + random sequence ----------------
  int order[$];
  int gaps[$];
  int expOrd[5];
  int expForced[12];
  int dc, zrun;
  logic lastV;
  logic [W-1:0] zval;

  initial begin
    maxHold[0] = 3;
    maxHold[1] = 0;
    zval = {W{1'bz}};

    // Reset and idle: reset asserted while source 0 drives 16'hABCD.
    req = '0; dataIn = '0;
    doReset();
    req = 4'b0001; setData(0, 16'hABCD);
    tick();
    chk("rst_pre_bus", 64'(busA), 64'(16'hABCD));
    #2;
    doReset();
    chk("rst_bus_z", 64'(busA), 64'(zval));
    chk("rst_grant", 64'(grantA), 64'd0);
    req = '0;
    repeat (5) begin
      tick();
      chk("idle_valid", 64'(validA), 64'd0);
    end

    // Single source with one-cycle data lag.
    doReset();
    req = 4'b0100; setData(2, 16'h1234);
    tick();
    chk("single_grant", 64'(grantA), 64'(4'b0100));
    chk("single_owner", 64'(ownerA), 64'd2);
    chk("single_bus", 64'(busA), 64'(16'h1234));
    setData(2, 16'h5678);
    #1;
    chk("single_no_comb", 64'(busA), 64'(16'h1234));
    tick();
    chk("single_follow", 64'(busA), 64'(16'h5678));
    req = '0;
    tick();
    chk("single_turn", 64'(dbgA), 64'(ST_TURN));
    tick();
    chk("single_idle", 64'(dbgA), 64'(ST_IDLE));

    // Round-robin fairness: all request, each drops after 2 drive cycles.
    doReset();
    expOrd = '{0, 1, 2, 3, 0};
    order.delete(); gaps.delete();
    dc = 0; zrun = 0; lastV = 1'b0;
    for (int c = 0; c < 60 && order.size() < 5; c++) begin
      req = (mdl[0].st == ST_DRIVE && dc == 2) ?
            (4'b1111 & ~(4'b0001 << mdl[0].owner)) : 4'b1111;
      dataIn = {$urandom, $urandom};
      tick();
      if (validA) begin
        if (!lastV) begin
          order.push_back(int'(ownerA));
          if (order.size() > 1) gaps.push_back(zrun);
        end
        zrun = 0;
      end else begin
        zrun++;
      end
      dc = (mdl[0].st == ST_DRIVE) ? dc + 1 : 0;
      lastV = validA;
    end
    chk("fair_count", 64'(order.size()), 64'd5);
    foreach (order[i]) chk($sformatf("fair_order%0d", i), 64'(order[i]), 64'(expOrd[i]));
    foreach (gaps[i]) chk($sformatf("fair_gap%0d", i), 64'(gaps[i]), 64'd1);

    // Forced release at MAX_HOLD=3 with sources 1 and 3 always requesting.
    doReset();
    expForced = '{1, 1, 1, -1, 3, 3, 3, -1, 1, 1, 1, -1};
    req = 4'b1010;
    for (int c = 0; c < 12; c++) begin
      dataIn = {$urandom, $urandom};
      tick();
      chk($sformatf("forced_valid%0d", c), 64'(validA), 64'(expForced[c] >= 0));
      if (expForced[c] >= 0)
        chk($sformatf("forced_owner%0d", c), 64'(ownerA), 64'(expForced[c]));
    end

    // Wrap: source 2 releases (pointer -> 3), then 0 and 2 request.
    doReset();
    req = 4'b0100;
    tick();
    req = 4'b0000;
    tick();
    chk("wrap_turn", 64'(dbgA), 64'(ST_TURN));
    req = 4'b0101;
    tick();
    chk("wrap_owner", 64'(ownerA), 64'd0);
    chk("wrap_grant", 64'(grantA), 64'(4'b0001));

    // Random contention run.
    doReset();
    for (int c = 0; c < 10000; c++) begin
      if ($urandom_range(0, 3) == 0) req = N'($urandom_range(0, 15));
      dataIn = {$urandom, $urandom};
      if ($urandom_range(0, 2999) == 0) begin
        #2;
        doReset();
      end
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/bus_arbiter_buffer.md
Name: bus_arbiter_buffer

Overview:
- Parametrised successor to the single-source tri-state ALU output buffer.
- Arbitrates NUM_SRC producers (ALU, memory, register file, immediate unit, etc.) for one shared tri-state data bus using a round-robin grant.
- Registers the winner's data and drives the bus from that register.
- Inserts a mandatory high-Z turnaround cycle between owners so two drivers are never on the bus together.
- Optionally limits how long one source can hold the bus.

Parameters:
- WIDTH, 16: bus and per-source data width in bits.
- NUM_SRC, 4: number of requesting sources. Must be at least 2.
- MAX_HOLD, 8: maximum consecutive DRIVE cycles per grant. 0 means unlimited.

Ports:
- clk, input, 1: single clock. All state updates on the rising edge.
- reset, input, 1: asynchronous, active-high reset.
- req, input, NUM_SRC: bit i is source i requesting the bus. It is level-sensitive and held for as long as the source wants the bus.
- data_in, input, NUM_SRC*WIDTH: source i data is in bits [i*WIDTH +: WIDTH].
- grant, output, NUM_SRC: one-hot registered grant. All zero when no source owns the bus.
- owner_id, output, clog2(NUM_SRC): index of the current owner. Valid only while bus_valid=1.
- bus_out, output (tri-state), WIDTH: shared bus. Driven from data_reg while bus_valid=1, otherwise all bits 'z'.
- bus_valid, output, 1: high in DRIVE state only.

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - state=IDLE, grant=0, owner_id=0, data_reg=0, hold_cnt=0, rr_ptr=0, bus_valid=0, bus_out=Z.
- Reset asserted mid-DRIVE releases the bus in the same cycle, with no turnaround.
- States are IDLE, DRIVE, TURNAROUND.
- Arbitration (applies at the rising edge in IDLE or TURNAROUND):
  - If any req bit is set, the winner is the first set bit searching upward from rr_ptr, wrapping at NUM_SRC-1 to 0.
  - On a win: grant<=onehot(winner), owner_id<=winner, data_reg<=data_in[winner], hold_cnt<=1, state<=DRIVE.
  - If no req bit is set, state<=IDLE.
- IDLE/TURNAROUND -> DRIVE:
  - The request is sampled at edge k.
  - After edge k: grant, bus_valid and the bus data are all present.
  - Latency from request to data on the bus is 1 edge.
- DRIVE, at each edge:
  - Release if req[owner_id]=0, or if MAX_HOLD!=0 and hold_cnt==MAX_HOLD.
  - On release: grant<=0, state<=TURNAROUND, rr_ptr<=(owner_id+1) mod NUM_SRC. data_reg keeps its value, but the bus is Z.
  - Otherwise: data_reg<=data_in[owner_id], hold_cnt<=hold_cnt+1 (saturating at MAX_HOLD; no wrap when unlimited), and the owner keeps the bus.
  - Bus data therefore lags data_in by exactly 1 cycle throughout ownership.
- TURNAROUND:
  - Lasts exactly 1 cycle, with the bus Z and bus_valid=0.
  - Arbitrates as above at its ending edge.
  - Minimum gap between two owners is one Z cycle.
- Forced release: when a hold is cut off by MAX_HOLD, rr_ptr still advances, so a source that keeps requesting waits for the others (fairness).
- Simultaneous requests: only round-robin order matters. A re-request by the previous owner in TURNAROUND loses to any other requester.
- Changes to req[j] for j != owner during DRIVE have no effect until the next arbitration.
- data_in of non-owners is ignored.
- hold_cnt width is clog2(MAX_HOLD+1), with a minimum of 1.
- No combinational path from req or data_in to bus_out. All outputs are registered or decoded from registers.

Decomposition:
- Shared package/include bus_arb_defs holds:
  - the state encodings (IDLE=2'd0, DRIVE=2'd1, TURNAROUND=2'd2);
  - the clog2 function used for owner_id/hold_cnt widths.
- One sub-module, rr_select: combinational. Takes req and rr_ptr and returns found and the winner index. Parametrised by NUM_SRC.
- The FSM, data register, counter and tri-state drive stay in the top module.

Test Plan:
- Reset and idle: assert reset mid-DRIVE while source 0 owns the bus with data 16'hABCD. bus_out must go to 16'hzzzz and grant to 0 immediately. After release with req=0 for 5 cycles, the bus stays Z and bus_valid stays 0.
- Single source: req=4'b0100, data_in[2]=16'h1234. After 1 edge: grant=4'b0100, owner_id=2, bus_out=16'h1234. Change data_in[2] to 16'h5678 and bus_out follows 1 cycle later. Drop req: 1 Z cycle follows, then IDLE.
- Round-robin fairness: req=4'b1111 held constant with MAX_HOLD=0 and each source dropping req after 2 DRIVE cycles, then re-raising it. Grant order must be 0,1,2,3,0, with exactly one Z cycle between owners.
- Forced release: MAX_HOLD=3, only req[1] and req[3] held high. Source 1 drives for exactly 3 cycles, then 1 Z cycle, then source 3 drives 3 cycles, then source 1 again.
- Wrap and priority: rr_ptr=3 after source 2 is released, with req=4'b0101 presented during TURNAROUND. Source 0 wins (wrap from 3 to 0), not source 2.
- Contention check: randomised req/data for 10k cycles. Assert bus_valid implies grant is one-hot, and that there is never a cycle where two grants are active or where DRIVE directly follows a DRIVE with a different owner_id.
